// File: rtl/echo_spi_slave.sv
// SPI mode-0 slave that serves the latest averaged echo width with status bits
// and captures a 16-bit command word; all SPI pins are oversampled on clk.
module echo_spi_slave #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] sample,
  input  logic        sample_valid,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic [15:0] cmd,
  output logic        cmd_valid,
  output logic        frame_done
);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  // Each pipe holds SYNC_STAGES synchronizer flops plus one edge-detect delay flop.
  logic [SYNC_STAGES:0] sck_pipe_q, sck_pipe_d;
  logic [SYNC_STAGES:0] cs_pipe_q, cs_pipe_d;
  logic [SYNC_STAGES:0] mosi_pipe_q, mosi_pipe_d;

  logic [11:0] hold_q, hold_d;
  logic        fresh_q, fresh_d;
  logic        overrun_q, overrun_d;
  logic [1:0]  seq_q, seq_d;

  state_t      state_q, state_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic        done_pend_q, done_pend_d;
  logic        miso_q, miso_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        frame_done_q, frame_done_d;

  logic        sck_rise, sck_fall, cs_rise, cs_fall, mosi_s, last_rise;
  logic [15:0] frame_word;

  assign sck_rise   = sck_pipe_q[SYNC_STAGES-1] & ~sck_pipe_q[SYNC_STAGES];
  assign sck_fall   = ~sck_pipe_q[SYNC_STAGES-1] & sck_pipe_q[SYNC_STAGES];
  assign cs_fall    = ~cs_pipe_q[SYNC_STAGES-1] & cs_pipe_q[SYNC_STAGES];
  assign cs_rise    = cs_pipe_q[SYNC_STAGES-1] & ~cs_pipe_q[SYNC_STAGES];
  assign mosi_s     = mosi_pipe_q[SYNC_STAGES-1];
  assign frame_word = {fresh_q, overrun_q, seq_q, hold_q};
  assign last_rise  = (state_q == ST_SHIFT) && !cs_rise && !cs_fall &&
                      sck_rise && (bitcnt_q == 5'd15);

  always_comb begin
    sck_pipe_d   = {sck_pipe_q[SYNC_STAGES-1:0], sck};
    cs_pipe_d    = {cs_pipe_q[SYNC_STAGES-1:0], cs_n};
    mosi_pipe_d  = {mosi_pipe_q[SYNC_STAGES-1:0], mosi};
    hold_d       = hold_q;
    fresh_d      = fresh_q;
    overrun_d    = overrun_q;
    seq_d        = seq_q;
    state_d      = state_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    bitcnt_d     = bitcnt_q;
    done_pend_d  = 1'b0;
    miso_d       = miso_q;
    cmd_d        = cmd_q;
    cmd_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    // A strobe coinciding with the end-of-frame clear wins over the clear.
    if (last_rise) begin
      fresh_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (sample_valid) begin
      hold_d  = sample;
      fresh_d = 1'b1;
      seq_d   = seq_q + 2'd1;
      if (fresh_q) overrun_d = 1'b1;
    end

    if (cs_rise) begin
      state_d = ST_IDLE;
      miso_d  = IDLE_MISO;
    end else if (cs_fall) begin
      state_d  = ST_SHIFT;
      tx_d     = frame_word;
      miso_d   = frame_word[15];
      bitcnt_d = 5'd0;
    end else if (state_q == ST_SHIFT) begin
      if (sck_rise && bitcnt_q != 5'd16) begin
        rx_d     = {rx_q[14:0], mosi_s};
        bitcnt_d = bitcnt_q + 5'd1;
        if (bitcnt_q == 5'd15) done_pend_d = 1'b1;
      end else if (sck_fall && bitcnt_q != 5'd0 && bitcnt_q != 5'd16) begin
        tx_d   = {tx_q[14:0], 1'b0};
        miso_d = tx_q[14];
      end
    end

    // One extra register stage so completion pulses land SYNC_STAGES+2 after the pin edge.
    if (done_pend_q) begin
      frame_done_d = 1'b1;
      cmd_valid_d  = 1'b1;
      cmd_d        = rx_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_pipe_q   <= '0;
      cs_pipe_q    <= '1;
      mosi_pipe_q  <= '0;
      hold_q       <= '0;
      fresh_q      <= 1'b0;
      overrun_q    <= 1'b0;
      seq_q        <= '0;
      state_q      <= ST_IDLE;
      tx_q         <= '0;
      rx_q         <= '0;
      bitcnt_q     <= '0;
      done_pend_q  <= 1'b0;
      miso_q       <= IDLE_MISO;
      cmd_q        <= '0;
      cmd_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sck_pipe_q   <= sck_pipe_d;
      cs_pipe_q    <= cs_pipe_d;
      mosi_pipe_q  <= mosi_pipe_d;
      hold_q       <= hold_d;
      fresh_q      <= fresh_d;
      overrun_q    <= overrun_d;
      seq_q        <= seq_d;
      state_q      <= state_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      bitcnt_q     <= bitcnt_d;
      done_pend_q  <= done_pend_d;
      miso_q       <= miso_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign miso       = miso_q;
  assign cmd        = cmd_q;
  assign cmd_valid  = cmd_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_echo_spi_slave.sv
// Directed + randomized bench for echo_spi_slave; expected frames come from a
// small status model (hold/fresh/overrun/seq/cmd) updated per strobe and per frame.
module tb_echo_spi_slave;
  localparam int   SYNC = 2;
  localparam logic IDLE = 1'b0;
  localparam int   H    = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] cmd;
  logic        cmd_valid;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int done_total = 0;
  int cv_total   = 0;

  logic [11:0] m_hold;
  logic        m_fresh, m_overrun;
  logic [1:0]  m_seq;
  logic [15:0] m_cmd;

  echo_spi_slave #(.SYNC_STAGES(SYNC), .IDLE_MISO(IDLE)) dut (
    .clk(clk), .reset(reset), .sample(sample), .sample_valid(sample_valid),
    .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso), .cmd(cmd),
    .cmd_valid(cmd_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done) done_total <= done_total + 1;
    if (cmd_valid)  cv_total   <= cv_total + 1;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = '0; m_fresh = 1'b0; m_overrun = 1'b0; m_seq = '0; m_cmd = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("reset_miso", {15'd0, miso}, {15'd0, IDLE});
    chk("reset_cmd", cmd, 16'h0000);
    chk("reset_pulses", {14'd0, cmd_valid, frame_done}, 16'h0000);
    cs_n = 1'b1; sck = 1'b0; mosi = 1'b0; sample_valid = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(SYNC + 3);
    model_reset();
  endtask

  task automatic strobe(input logic [11:0] v);
    sample = v; sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    if (m_fresh) m_overrun = 1'b1;
    m_fresh = 1'b1;
    m_seq   = m_seq + 2'd1;
    m_hold  = v;
  endtask

  // Runs one transfer of nbits sck pulses; optionally strobes a sample in the
  // cycle the 16th rise is seen, optionally leaves cs_n low at the end.
  task automatic frame(input string tag, input logic [15:0] mosi_word, input int nbits,
                       input bit inject, input logic [11:0] inj_val, input bit keep_cs);
    logic [15:0] exp_word, got;
    int d0, c0;
    bit pre;
    exp_word = {m_fresh, m_overrun, m_seq, m_hold};
    got = '0;
    d0 = done_total; c0 = cv_total;
    cs_n = 1'b0;
    tick(SYNC + 2);
    for (int i = 0; i < nbits; i++) begin
      mosi = mosi_word[15-i];
      tick(H);
      got[15-i] = miso;
      sck = 1'b1;
      if (inject && i == 15) begin
        tick(SYNC);
        sample = inj_val; sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
        tick(H - SYNC - 1);
      end else begin
        tick(H);
      end
      sck = 1'b0;
    end
    if (keep_cs) return;
    tick(H);
    cs_n = 1'b1;
    tick(SYNC + 3);
    chk({tag, "_miso_prefix"}, got >> (16 - nbits), exp_word >> (16 - nbits));
    if (nbits == 16) begin
      pre = m_fresh;
      m_fresh = 1'b0; m_overrun = 1'b0; m_cmd = mosi_word;
      if (inject) begin
        m_overrun = pre; m_fresh = 1'b1; m_seq = m_seq + 2'd1; m_hold = inj_val;
      end
    end
    chk({tag, "_frame_done_cnt"}, 16'(done_total - d0), (nbits == 16) ? 16'd1 : 16'd0);
    chk({tag, "_cmd_valid_cnt"}, 16'(cv_total - c0), (nbits == 16) ? 16'd1 : 16'd0);
    chk({tag, "_cmd"}, cmd, m_cmd);
    $display("[TB] %s: mosi=%h bits=%0d miso=%h expected=%h", tag, mosi_word, nbits,
             got, exp_word);
  endtask

  initial begin
    logic [15:0] w;
    model_reset();
    tick(2);
    do_reset();

    strobe(12'hABC);
    chk("frame_word_9abc", {m_fresh, m_overrun, m_seq, m_hold}, 16'h9ABC);
    frame("basic", 16'h1234, 16, 0, '0, 0);
    chk("cmd_1234", cmd, 16'h1234);
    frame("reread", 16'($urandom), 16, 0, '0, 0);

    do_reset();
    strobe(12'h100); strobe(12'h200); strobe(12'h300);
    frame("overrun", 16'($urandom), 16, 0, '0, 0);
    frame("after_overrun", 16'($urandom), 16, 0, '0, 0);

    do_reset();
    frame("pre_abort", 16'hBEEF, 16, 0, '0, 0);
    strobe(12'h444);
    frame("abort", 16'($urandom), 7, 0, '0, 0);
    frame("after_abort", 16'($urandom), 16, 0, '0, 0);

    do_reset();
    strobe(12'h555);
    frame("simul", 16'($urandom), 16, 1, 12'h0DE, 0);
    frame("after_simul", 16'($urandom), 16, 0, '0, 0);

    do_reset();
    for (int k = 0; k < 5; k++) begin
      strobe(12'($urandom));
      frame("seq_wrap", 16'($urandom), 16, 0, '0, 0);
    end

    for (int k = 0; k < 6; k++) begin
      int ns;
      ns = $urandom_range(0, 3);
      for (int j = 0; j < ns; j++) strobe(12'($urandom));
      frame("random", 16'($urandom), 16, 0, '0, 0);
    end

    strobe(12'hFFF);
    w = 16'($urandom);
    frame("mid_reset", w, 9, 0, '0, 1);
    chk("miso_before_reset", {15'd0, miso}, 16'd1);
    do_reset();
    frame("post_reset", w, 16, 0, '0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
